// File: rtl/ship_setup_pkg.sv
// ----------------------------------------------------------------------------
// ship_setup_pkg
// Shared types and default constants for the ship setup controller.
//   setup_state_t   : controller FSM state encoding
//   DEF_MAX_SHIPS   : default maximum ships per player
//   DEF_NUM_PLAYERS : default number of players placing in turn
// ----------------------------------------------------------------------------
package ship_setup_pkg;

    localparam int unsigned DEF_MAX_SHIPS   = 5;
    localparam int unsigned DEF_NUM_PLAYERS = 2;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DECIDE      = 3'd1,
        PLACE       = 3'd2,
        NEXT_PLAYER = 3'd3,
        DONE        = 3'd4
    } setup_state_t;

endpackage : ship_setup_pkg

// File: rtl/ship_setup_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up/down counter saturating at 0 and at a runtime limit.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force count to 0 (highest priority after reset)
//   inc, dec : step up / down; both together hold the count
//   limit    : upper saturation value
//   count    : registered count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !dec && (count < limit)) begin
            count <= count + W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/ship_setup_ctrl.sv
// ----------------------------------------------------------------------------
// ship_setup_ctrl
// Setup-phase controller: latches the ship amount, then lets each player in
// turn place that many ships, and reports when every player is done.
// Optional feature macro: SHIP_UNDO_EN (place_undo removes the last ship).
//   clk, rst       : clock, synchronous active-high reset
//   decision_state : game controller is in the setup phase (drop = abort)
//   amount_in      : requested ship count per player
//   confirm        : pulse, accept amount_in (DECIDE only)
//   place_valid    : pulse, current player placed a ship (PLACE only)
//   place_undo     : pulse, current player removed a ship (PLACE only)
//   ships_decided  : a legal amount has been latched
//   ship_amount    : latched ship amount
//   ships_placed   : ships placed by the current player
//   player_id      : player currently placing
//   amount_err     : one-cycle pulse on an illegal confirm
//   setup_done     : all players have finished placing
// ----------------------------------------------------------------------------
module ship_setup_ctrl
    import ship_setup_pkg::*;
#(
    parameter  int unsigned MAX_SHIPS   = DEF_MAX_SHIPS,
    parameter  int unsigned NUM_PLAYERS = DEF_NUM_PLAYERS,
    localparam int unsigned CNT_W       = $clog2(MAX_SHIPS + 1),
    localparam int unsigned PID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             decision_state,
    input  logic [CNT_W-1:0] amount_in,
    input  logic             confirm,
    input  logic             place_valid,
    input  logic             place_undo,
    output logic             ships_decided,
    output logic [CNT_W-1:0] ship_amount,
    output logic [CNT_W-1:0] ships_placed,
    output logic [PID_W-1:0] player_id,
    output logic             amount_err,
    output logic             setup_done
);

    setup_state_t state, state_next;

    logic             amount_legal;
    logic             last_player;
    logic             inc_req;
    logic             dec_req;
    logic             place_done;
    logic [CNT_W:0]   placed_p1;

    logic             cnt_inc;
    logic             cnt_dec;
    logic             cnt_clr;
    logic             latch_amount;
    logic             err_set;
    logic             pid_inc;
    logic             sess_clr;

    // Placement request decode; simultaneous place and undo cancel out
`ifdef SHIP_UNDO_EN
    assign inc_req = place_valid & ~place_undo;
    assign dec_req = place_undo & ~place_valid;
`else
    logic unused_place_undo;
    assign unused_place_undo = place_undo;
    assign inc_req = place_valid;
    assign dec_req = 1'b0;
`endif

    assign amount_legal = (amount_in != '0) && (amount_in <= CNT_W'(MAX_SHIPS));
    assign last_player  = (player_id == PID_W'(NUM_PLAYERS - 1));
    assign placed_p1    = {1'b0, ships_placed} + {{CNT_W{1'b0}}, 1'b1};
    assign place_done   = inc_req && (placed_p1 == {1'b0, ship_amount});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; dropping decision_state always returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (decision_state) state_next = DECIDE;
            end
            DECIDE: begin
                if (!decision_state)               state_next = IDLE;
                else if (confirm && amount_legal)  state_next = PLACE;
            end
            PLACE: begin
                if (!decision_state)  state_next = IDLE;
                else if (place_done)  state_next = last_player ? DONE : NEXT_PLAYER;
            end
            NEXT_PLAYER: begin
                state_next = decision_state ? PLACE : IDLE;
            end
            DONE: begin
                if (!decision_state) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control decode for the datapath registers and the placement counter
    always_comb begin
        cnt_inc      = 1'b0;
        cnt_dec      = 1'b0;
        cnt_clr      = 1'b0;
        latch_amount = 1'b0;
        err_set      = 1'b0;
        pid_inc      = 1'b0;
        sess_clr     = 1'b0;
        if (state != IDLE && !decision_state) begin
            sess_clr = 1'b1;
            cnt_clr  = 1'b1;
        end else begin
            case (state)
                DECIDE: begin
                    if (confirm) begin
                        if (amount_legal) begin
                            latch_amount = 1'b1;
                            cnt_clr      = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
                PLACE: begin
                    cnt_inc = inc_req;
                    cnt_dec = dec_req;
                end
                NEXT_PLAYER: begin
                    pid_inc = 1'b1;
                    cnt_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; ship_amount survives an abort
    always_ff @(posedge clk) begin
        if (rst) begin
            ships_decided <= 1'b0;
            ship_amount   <= '0;
            player_id     <= '0;
            amount_err    <= 1'b0;
            setup_done    <= 1'b0;
        end else begin
            amount_err <= err_set;
            setup_done <= (state_next == DONE);
            if (latch_amount) begin
                ship_amount   <= amount_in;
                ships_decided <= 1'b1;
            end
            if (sess_clr) begin
                ships_decided <= 1'b0;
                player_id     <= '0;
            end else if (pid_inc) begin
                player_id <= player_id + PID_W'(1);
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_placed_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clr),
        .inc   (cnt_inc),
        .dec   (cnt_dec),
        .limit (ship_amount),
        .count (ships_placed)
    );

endmodule : ship_setup_ctrl

// File: tb/tb_ship_setup_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ship_setup_ctrl
// Self-checking bench for ship_setup_ctrl with default parameters
// (MAX_SHIPS=5, NUM_PLAYERS=2). Each vector is driven on the falling edge,
// its expected outputs queued, and the queue popped and compared just after
// the following rising edge.
// ----------------------------------------------------------------------------
module tb_ship_setup_ctrl;
    import ship_setup_pkg::*;

    localparam int unsigned MAX_SHIPS   = DEF_MAX_SHIPS;
    localparam int unsigned NUM_PLAYERS = DEF_NUM_PLAYERS;
    localparam int unsigned CNT_W       = $clog2(MAX_SHIPS + 1);
    localparam int unsigned PID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    logic             clk;
    logic             rst;
    logic             decision_state;
    logic [CNT_W-1:0] amount_in;
    logic             confirm;
    logic             place_valid;
    logic             place_undo;
    logic             ships_decided;
    logic [CNT_W-1:0] ship_amount;
    logic [CNT_W-1:0] ships_placed;
    logic [PID_W-1:0] player_id;
    logic             amount_err;
    logic             setup_done;

    typedef struct packed {
        logic             decided;
        logic [CNT_W-1:0] amount;
        logic [CNT_W-1:0] placed;
        logic [PID_W-1:0] pid;
        logic             err;
        logic             done;
    } out_t;

    typedef struct {
        logic             rst;
        logic             ds;
        logic [CNT_W-1:0] amt;
        logic             cf;
        logic             pv;
        logic             pu;
        out_t             exp;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_idx = 0;
    out_t exp_q[$];
    vec_t vecs[$];

    ship_setup_ctrl #(
        .MAX_SHIPS   (MAX_SHIPS),
        .NUM_PLAYERS (NUM_PLAYERS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .decision_state (decision_state),
        .amount_in      (amount_in),
        .confirm        (confirm),
        .place_valid    (place_valid),
        .place_undo     (place_undo),
        .ships_decided  (ships_decided),
        .ship_amount    (ship_amount),
        .ships_placed   (ships_placed),
        .player_id      (player_id),
        .amount_err     (amount_err),
        .setup_done     (setup_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic d, input int a, input logic c,
                                input logic v, input logic u, input logic e_dec,
                                input int e_amt, input int e_pl, input int e_pid,
                                input logic e_err, input logic e_done);
        vec_t t;
        t.rst         = r;
        t.ds          = d;
        t.amt         = CNT_W'(a);
        t.cf          = c;
        t.pv          = v;
        t.pu          = u;
        t.exp.decided = e_dec;
        t.exp.amount  = CNT_W'(e_amt);
        t.exp.placed  = CNT_W'(e_pl);
        t.exp.pid     = PID_W'(e_pid);
        t.exp.err     = e_err;
        t.exp.done    = e_done;
        return t;
    endfunction

    task automatic check_one();
        out_t got;
        out_t exp;
        exp = exp_q.pop_front();
        got = {ships_decided, ship_amount, ships_placed, player_id, amount_err, setup_done};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL vec%0d: got dec=%0d amt=%0d placed=%0d pid=%0d err=%0d done=%0d, want dec=%0d amt=%0d placed=%0d pid=%0d err=%0d done=%0d",
                     vec_idx, got.decided, got.amount, got.placed, got.pid, got.err, got.done,
                     exp.decided, exp.amount, exp.placed, exp.pid, exp.err, exp.done);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst            = v.rst;
        decision_state = v.ds;
        amount_in      = v.amt;
        confirm        = v.cf;
        place_valid    = v.pv;
        place_undo     = v.pu;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        check_one();
        vec_idx++;
    endtask

    task automatic step(input logic r, input logic d, input int a, input logic c,
                        input logic v, input logic u, input logic e_dec,
                        input int e_amt, input int e_pl, input int e_pid,
                        input logic e_err, input logic e_done);
        apply(mk(r, d, a, c, v, u, e_dec, e_amt, e_pl, e_pid, e_err, e_done));
    endtask

    initial begin
        rst            = 1'b1;
        decision_state = 1'b0;
        amount_in      = '0;
        confirm        = 1'b0;
        place_valid    = 1'b0;
        place_undo     = 1'b0;

        //                rst ds amt cf pv pu | dec amt pl pid err done
        // reset and IDLE
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 1, 1, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        // illegal amounts: 0, MAX+1, 7
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 6, 1, 0, 0,   0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 6, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 7, 1, 0, 0,   0, 0, 0, 0, 1, 0));
        // legal flow, amount 3, two players
        vecs.push_back(mk(0, 1, 3, 1, 0, 0,   1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5, 1, 0, 0,   1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   1, 3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   1, 3, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   1, 3, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   1, 3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   1, 3, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   1, 3, 2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   1, 3, 3, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0,   1, 3, 3, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0));
        // abort after two placements, amount retained
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5, 1, 0, 0,   1, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   1, 5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   1, 5, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,   0, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,   0, 5, 0, 0, 0, 0));
        // reset for two cycles mid-placement
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 1, 0, 0,   1, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   1, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        // amount 1, reset while in DONE
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,   1, 1, 1, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // undo sequence: place, place, undo x3, place+undo, place, place+undo
        step(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 1, 0, 0,   1, 5, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0,   1, 5, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0,   1, 5, 2, 0, 0, 0);
`ifdef SHIP_UNDO_EN
        step(0, 1, 0, 0, 0, 1,   1, 5, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1,   1, 5, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1,   1, 5, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 1,   1, 5, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0,   1, 5, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 1,   1, 5, 1, 0, 0, 0);
`else
        step(0, 1, 0, 0, 0, 1,   1, 5, 2, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1,   1, 5, 2, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1,   1, 5, 2, 0, 0, 0);
        step(0, 1, 0, 0, 1, 1,   1, 5, 3, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0,   1, 5, 4, 0, 0, 0);
        step(0, 1, 0, 0, 1, 1,   1, 5, 5, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1,   1, 5, 0, 1, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ship_setup_ctrl

// File: doc/ship_setup_ctrl.md
SHIP_SETUP_CTRL -- requirements
Module: ship_setup_ctrl

Interface
REQ-001 SHALL have parameter MAX_SHIPS, default 5, meaning the maximum ships per player (legal range 1..7).
REQ-002 SHALL have parameter NUM_PLAYERS, default 2, meaning the number of players placing ships in turn (legal range 1..4).
REQ-003 SHALL have derived localparams CNT_W = $clog2(MAX_SHIPS+1) and PID_W = max(1, $clog2(NUM_PLAYERS)).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port decision_state, input, 1 bit: the game controller is in the setup phase.
REQ-007 SHALL have port amount_in, input, CNT_W bits: the requested ship count per player.
REQ-008 SHALL have port confirm, input, 1 bit: a single-cycle pulse that accepts amount_in.
REQ-009 SHALL have port place_valid, input, 1 bit: a single-cycle pulse meaning the current player placed one ship.
REQ-010 SHALL have port place_undo, input, 1 bit: a single-cycle pulse meaning the current player removed the last ship.
REQ-011 SHALL have port ships_decided, output, 1 bit: a level that is high once a legal amount has been latched.
REQ-012 SHALL have port ship_amount, output, CNT_W bits: the latched ship amount.
REQ-013 SHALL have port ships_placed, output, CNT_W bits: the ships placed by the current player.
REQ-014 SHALL have port player_id, output, PID_W bits: the index of the player currently placing.
REQ-015 SHALL have port amount_err, output, 1 bit: a one-cycle pulse for an illegal confirm.
REQ-016 SHALL have port setup_done, output, 1 bit: a level that is high when all players have finished placing.

Function
REQ-017 SHALL implement the FSM states IDLE, DECIDE, PLACE, NEXT_PLAYER and DONE.
REQ-018 SHALL transition from IDLE to DECIDE on the first cycle in which decision_state=1.
REQ-019 SHALL, in DECIDE, on confirm with 1<=amount_in<=MAX_SHIPS: latch ship_amount, set ships_decided=1 and go to PLACE on the next edge, giving 1-cycle latency.
REQ-020 SHALL, in DECIDE, on confirm with amount_in=0 or amount_in>MAX_SHIPS: pulse amount_err for exactly 1 cycle, stay in DECIDE and leave ship_amount unchanged.
REQ-021 SHALL, in PLACE, increment ships_placed by 1 on each place_valid.
REQ-022 SHALL, in PLACE, on a place_valid that makes ships_placed reach ship_amount: go to DONE if player_id=NUM_PLAYERS-1, else go to NEXT_PLAYER.
REQ-023 SHALL, in NEXT_PLAYER (exactly 1 cycle): increment player_id, clear ships_placed to 0 and return to PLACE; place_valid in this cycle is ignored.
REQ-024 SHALL hold setup_done=1 in DONE and ignore all place and confirm inputs there.
REQ-025 SHALL leave DONE for IDLE when decision_state=0.
REQ-026 SHALL, on decision_state=0 while in DECIDE, PLACE or NEXT_PLAYER: abort to IDLE on the next edge and clear ships_decided, ships_placed and player_id; ship_amount is retained.
REQ-027 SHALL ignore confirm outside DECIDE and place_valid/place_undo outside PLACE.
REQ-028 SHALL never wrap ships_placed past ship_amount or below 0.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, set state=IDLE and all outputs to 0: ships_decided, ship_amount, ships_placed, player_id, amount_err and setup_done.
REQ-030 SHALL give rst priority over every other input, including mid-placement and in DONE.

Configuration
REQ-031 SHALL, when macro SHIP_UNDO_EN is defined, in PLACE decrement ships_placed on place_undo (saturating at 0).
REQ-032 SHALL, when SHIP_UNDO_EN is defined, treat simultaneous place_valid and place_undo as no change.
REQ-033 SHALL, when SHIP_UNDO_EN is undefined, keep the place_undo port present but ignore it entirely.

Structure
REQ-034 SHALL place the state enum type setup_state_t and the default constants DEF_MAX_SHIPS=5 and DEF_NUM_PLAYERS=2 in shared package ship_setup_pkg.
REQ-035 SHALL implement ships_placed with one sub-module, sat_counter, parametrised by width, with inc, dec and clear inputs and saturation at 0 and at a runtime limit input.

Verification
REQ-036 SHALL verify reset: rst=1 for 2 cycles during PLACE -> state=IDLE and all outputs 0 on the next cycle.
REQ-037 SHALL verify a legal flow: NUM_PLAYERS=2, amount_in=3, confirm, then 6 place_valid pulses -> player_id goes 0->1 after the 3rd pulse, and setup_done=1 after the 6th.
REQ-038 SHALL verify illegal amounts: confirm with amount_in=0, then with 6 (MAX_SHIPS=5) -> amount_err pulses once each, ships_decided stays 0 and state stays DECIDE.
REQ-039 SHALL verify abort: decision_state drops after 2 placements -> IDLE, with ships_placed=0, player_id=0 and ships_decided=0.
REQ-040 SHALL verify undo (SHIP_UNDO_EN defined): place, place, undo, undo, undo -> ships_placed goes 1,2,1,0,0; simultaneous place_valid and place_undo -> unchanged.
REQ-041 SHALL verify NEXT_PLAYER masking: place_valid asserted during NEXT_PLAYER -> ignored, so the new player's ships_placed=0.
